// File: rtl/led_matrix_scan_driver.sv
// LED dot-matrix scan driver: double-buffered row store fed over valid/ready,
// multiplexed onto the panel one row at a time with per-row blanking.
module led_matrix_scan_driver #(
  parameter int unsigned ROWS     = 7,
  parameter int unsigned COLS     = 5,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned BLANK    = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [COLS-1:0] in_data,
  input  logic            in_valid,
  input  logic            in_sof,
  output logic            in_ready,
  output logic [COLS-1:0] col_out,
  output logic [ROWS-1:0] row_sel_n,
  output logic            frame_tick,
  output logic            sync_err
);

  localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned PreW = $clog2(PRESCALE);

  localparam logic [RowW-1:0] LastRow  = RowW'(ROWS - 1);
  localparam logic [PreW-1:0] LastPre  = PreW'(PRESCALE - 1);
  localparam logic [PreW-1:0] BlankCnt = PreW'(BLANK);

  logic [COLS-1:0] back_q  [ROWS];
  logic [COLS-1:0] back_d  [ROWS];
  logic [COLS-1:0] front_q [ROWS];
  logic [COLS-1:0] front_d [ROWS];

  logic [RowW-1:0] wr_ptr_q, wr_ptr_d;
  logic            pending_q, pending_d;
  logic [RowW-1:0] scan_row_q, scan_row_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;

  logic [COLS-1:0] col_out_q, col_out_d;
  logic [ROWS-1:0] row_sel_n_q, row_sel_n_d;
  logic            frame_tick_q, frame_tick_d;
  logic            sync_err_q, sync_err_d;

  logic accept;
  logic wrap_row;
  logic wrap_frame;

  // A completed frame blocks the write side until it has been swapped to the front.
  assign in_ready   = ~pending_q;
  assign col_out    = col_out_q;
  assign row_sel_n  = row_sel_n_q;
  assign frame_tick = frame_tick_q;
  assign sync_err   = sync_err_q;

  // Next-state for scan timing, buffer swap, write side and registered panel outputs.
  always_comb begin
    back_d       = back_q;
    front_d      = front_q;
    wr_ptr_d     = wr_ptr_q;
    pending_d    = pending_q;
    scan_row_d   = scan_row_q;
    pre_cnt_d    = pre_cnt_q;
    sync_err_d   = 1'b0;

    accept     = in_valid && !pending_q;
    wrap_row   = (pre_cnt_q == LastPre);
    wrap_frame = wrap_row && (scan_row_q == LastRow);

    if (wrap_row) begin
      pre_cnt_d  = '0;
      scan_row_d = wrap_frame ? '0 : scan_row_q + 1'b1;
    end else begin
      pre_cnt_d  = pre_cnt_q + 1'b1;
    end

    // Swap uses the pre-edge pending flag, so a frame finishing on the wrap edge waits a frame.
    if (wrap_frame && pending_q) begin
      front_d   = back_q;
      pending_d = 1'b0;
    end

    if (accept) begin
      if (in_sof) begin
        back_d[0]  = in_data;
        wr_ptr_d   = RowW'(1);
        sync_err_d = (wr_ptr_q != '0);
      end else if (wr_ptr_q == '0) begin
        sync_err_d = 1'b1;
      end else begin
        back_d[wr_ptr_q] = in_data;
        if (wr_ptr_q == LastRow) begin
          wr_ptr_d  = '0;
          pending_d = 1'b1;
        end else begin
          wr_ptr_d  = wr_ptr_q + 1'b1;
        end
      end
    end

    row_sel_n_d  = ~(ROWS'(1) << scan_row_q);
    col_out_d    = (pre_cnt_q < BlankCnt) ? '0 : front_q[scan_row_q];
    frame_tick_d = wrap_frame;
  end

  // State and output registers with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      back_q       <= '{default: '0};
      front_q      <= '{default: '0};
      wr_ptr_q     <= '0;
      pending_q    <= 1'b0;
      scan_row_q   <= '0;
      pre_cnt_q    <= '0;
      col_out_q    <= '0;
      row_sel_n_q  <= '1;
      frame_tick_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      back_q       <= back_d;
      front_q      <= front_d;
      wr_ptr_q     <= wr_ptr_d;
      pending_q    <= pending_d;
      scan_row_q   <= scan_row_d;
      pre_cnt_q    <= pre_cnt_d;
      col_out_q    <= col_out_d;
      row_sel_n_q  <= row_sel_n_d;
      frame_tick_q <= frame_tick_d;
      sync_err_q   <= sync_err_d;
    end
  end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Bench for led_matrix_scan_driver: cycle-count based scan model plus
// directed frames with hand-computed panel contents.
module tb_led_matrix_scan_driver;

  localparam int unsigned R = 7;
  localparam int unsigned C = 5;
  localparam int unsigned P = 4;
  localparam int unsigned B = 1;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [C-1:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_sof = 1'b0;
  logic         in_ready;
  logic [C-1:0] col_out;
  logic [R-1:0] row_sel_n;
  logic         frame_tick;
  logic         sync_err;

  int vectors = 0;
  int miscompares = 0;
  int sync_cnt = 0;

  led_matrix_scan_driver #(
    .ROWS     (R),
    .COLS     (C),
    .PRESCALE (P),
    .BLANK    (B)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .in_ready   (in_ready),
    .col_out    (col_out),
    .row_sel_n  (row_sel_n),
    .frame_tick (frame_tick),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: scan position follows directly from the cycle count since reset.
  int           m_cyc;
  int           m_row;
  int           m_pre;
  bit           m_wrap;
  bit           m_old_pend;
  logic [C-1:0] m_back  [R];
  logic [C-1:0] m_front [R];
  int           m_wr;
  bit           m_pend;
  logic [C-1:0] e_col;
  logic [R-1:0] e_row;
  logic         e_tick;
  logic         e_err;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_cyc = 0;
        m_wr = 0;
        m_pend = 0;
        for (int i = 0; i < R; i++) begin
          m_back[i] = '0;
          m_front[i] = '0;
        end
        e_col = '0;
        e_row = '1;
        e_tick = 1'b0;
        e_err = 1'b0;
      end else begin
        m_row = (m_cyc / P) % R;
        m_pre = m_cyc % P;
        m_wrap = (m_cyc % (P * R)) == (P * R - 1);
        e_row = ~(7'(1) << m_row);
        e_col = (m_pre < B) ? '0 : m_front[m_row];
        e_tick = m_wrap;
        e_err = 1'b0;
        m_old_pend = m_pend;
        if (m_wrap && m_old_pend) begin
          m_front = m_back;
          m_pend = 0;
        end
        if (in_valid && !m_old_pend) begin
          if (in_sof) begin
            if (m_wr != 0) e_err = 1'b1;
            m_back[0] = in_data;
            m_wr = 1;
          end else if (m_wr == 0) begin
            e_err = 1'b1;
          end else begin
            m_back[m_wr] = in_data;
            m_wr++;
            if (m_wr == R) begin
              m_wr = 0;
              m_pend = 1;
            end
          end
        end
        m_cyc++;
      end
    end
  end

  // Compare every cycle against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("col_out", col_out, e_col);
      chk("row_sel_n", row_sel_n, e_row);
      chk("frame_tick", frame_tick, e_tick);
      chk("sync_err", sync_err, e_err);
      chk("in_ready", in_ready, !m_pend);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (sync_err === 1'b1) sync_cnt++;
    end
  end

  task automatic wait_tick(input string name);
    bit found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) found = 1;
    end
    if (!found) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: frame_tick not seen within 100 cycles", name);
    end
  endtask

  task automatic send(input logic [C-1:0] d, input bit sof);
    in_data = d;
    in_sof = sof;
    in_valid = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_sof = 1'b0;
  endtask

  // Called at the negedge right after a wrap: row 0 blank cycle, 3 data cycles, then row 1.
  task automatic show_rows(input string name, input logic [C-1:0] r0, input logic [C-1:0] r1);
    @(negedge clk);
    chk({name, " row0 sel"}, row_sel_n, 7'b1111110);
    chk({name, " row0 blank"}, col_out, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk({name, " row0 data"}, col_out, r0);
    end
    @(negedge clk);
    chk({name, " row1 sel"}, row_sel_n, 7'b1111101);
    chk({name, " row1 blank"}, col_out, 0);
    @(negedge clk);
    chk({name, " row1 data"}, col_out, r1);
  endtask

  logic [C-1:0] f0 [R] = '{5'h0E, 5'h0A, 5'h0E, 5'h0A, 5'h0A, 5'h00, 5'h00};
  logic [C-1:0] fb [R] = '{5'h11, 5'h1F, 5'h04, 5'h04, 5'h04, 5'h1F, 5'h11};
  logic [C-1:0] fc [R] = '{5'h18, 5'h11, 5'h11, 5'h11, 5'h11, 5'h11, 5'h1F};
  logic [C-1:0] fd [R] = '{5'h03, 5'h06, 5'h0C, 5'h18, 5'h0C, 5'h06, 5'h03};

  initial begin
    int cnt;
    bit seen;
    #22 reset_n = 1'b1;

    // Free run: tick period, row stepping, blank panel.
    wait_tick("first tick");
    cnt = 0;
    seen = 0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      cnt++;
      if (cnt == 1) chk("free row0", row_sel_n, 7'b1111110);
      if (cnt == 3) chk("free col zero", col_out, 0);
      if (cnt == 5) chk("free row1", row_sel_n, 7'b1111101);
      if (frame_tick === 1'b1) seen = 1;
    end
    chk("tick period", cnt, 28);

    // Clean frame, no gaps.
    for (int i = 0; i < R; i++) send(f0[i], i == 0);
    idle();
    chk("ready low after frame", in_ready, 0);
    wait_tick("f0 swap");
    chk("ready after swap", in_ready, 1);
    show_rows("f0", 5'h0E, 5'h0A);

    // sof on the 4th word abandons the partial frame.
    wait_tick("fb sync");
    sync_cnt = 0;
    send(5'h15, 1'b1);
    send(5'h14, 1'b0);
    send(5'h13, 1'b0);
    for (int i = 0; i < R; i++) send(fb[i], i == 0);
    idle();
    chk("fb ready low", in_ready, 0);
    repeat (2) @(negedge clk);
    chk("fb sync_err pulses", sync_cnt, 1);
    wait_tick("fb swap");
    show_rows("fb", 5'h11, 5'h1F);

    // Non-sof word with no frame open is dropped.
    wait_tick("fc sync");
    sync_cnt = 0;
    send(5'h07, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    chk("drop sync_err pulses", sync_cnt, 1);
    for (int i = 0; i < R; i++) send(fc[i], i == 0);
    idle();
    wait_tick("fc swap");
    show_rows("fc", 5'h18, 5'h11);

    // Last word lands on the wrap edge: swap deferred one full frame.
    wait_tick("fd sync");
    repeat (21) @(negedge clk);
    for (int i = 0; i < R; i++) send(fd[i], i == 0);
    idle();
    chk("fd tick at completion", frame_tick, 1);
    chk("fd ready low at wrap", in_ready, 0);
    for (int i = 1; i < 28; i++) begin
      @(negedge clk);
      chk("fd ready held low", in_ready, 0);
      if (i == 2) chk("fd old frame kept", col_out, 5'h18);
    end
    @(negedge clk);
    chk("fd deferred tick", frame_tick, 1);
    chk("fd ready after swap", in_ready, 1);
    show_rows("fd", 5'h03, 5'h06);

    // Asynchronous reset mid-scan with a frame pending.
    wait_tick("rst sync");
    for (int i = 0; i < R; i++) send(5'h1F, i == 0);
    idle();
    repeat (3) @(negedge clk);
    chk("pre-reset row2 data", col_out, 5'h0C);
    #2 reset_n = 1'b0;
    #1;
    chk("rst col_out", col_out, 0);
    chk("rst row_sel_n", row_sel_n, 7'b1111111);
    chk("rst in_ready", in_ready, 1);
    chk("rst frame_tick", frame_tick, 0);
    chk("rst sync_err", sync_err, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1 chk("post-reset ready", in_ready, 1);
    wait_tick("post-reset tick");
    show_rows("post-reset blank", 5'h00, 5'h00);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
